// File: rtl/mdu_mips.sv
// Iterative MIPS multiply/divide unit with HI/LO registers, one bit per cycle.
// Optional MADD/MADDU accumulate enabled by defining MDU_MADD_EN.
module mdu_mips #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             is_div_q, is_madd_q, neg_res_q, neg_rem_q, dz_q;
  logic [WIDTH-1:0] opnd_q, acc_hi_q, acc_lo_q, hi_q, lo_q;
  logic             done_q, div_zero_q;

  logic             op_reserved, op_div, op_signed, accept;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign op_reserved = op[2] & op[1];
  assign op_div      = ~op[2] & op[1];
  assign op_signed   = ~op[0];
  assign accept      = (state_q == StIdle) && start && !op_reserved;

  assign a_mag = (op_signed && a_in[WIDTH-1]) ? -a_in : a_in;
  assign b_mag = (op_signed && b_in[WIDTH-1]) ? -b_in : b_in;

  // Multiply: acc_lo holds the multiplier and shifts right as product bits arrive.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
  // Divide: acc_lo holds the dividend and shifts left as quotient bits arrive.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quot_fix = neg_res_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      is_madd_q  <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      opnd_q     <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            is_div_q  <= op_div;
            is_madd_q <= op[2];
            neg_res_q <= op_signed & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
            neg_rem_q <= op_signed & op_div & a_in[WIDTH-1];
            dz_q      <= op_div && (b_in == '0);
            acc_hi_q  <= '0;
            acc_lo_q  <= op_div ? a_mag : b_mag;
            opnd_q    <= op_div ? b_mag : a_mag;
            cnt_q     <= CNT_W'(WIDTH - 1);
            state_q   <= StRun;
          end else begin
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        StRun: begin
          if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
              acc_hi_q <= div_diff[WIDTH-1:0];
              acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi_q <= div_shift[WIDTH-1:0];
              acc_lo_q <= {acc_lo_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi_q <= mul_sum[WIDTH:1];
            acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= StFix;
        end
        StFix: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
          if (is_div_q) begin
            div_zero_q <= dz_q;
            lo_q       <= dz_q ? '1 : quot_fix;
            // With a zero divisor the remainder is |a| re-signed, i.e. a itself.
            hi_q       <= rem_fix;
          end else if (!is_madd_q) begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
`ifdef MDU_MADD_EN
          else begin
            {hi_q, lo_q} <= {hi_q, lo_q} + prod_fix;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_mdu_mips.sv
// Self-checking bench for mdu_mips: directed cases plus random traffic against
// a cycle-level behavioural model computed with plain integer arithmetic.
module tb_mdu_mips;
  localparam int unsigned WIDTH = 32;

  logic             clk, rst_n, start, hi_we, lo_we;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_in, b_in, wdata;
  logic             busy, done, div_zero;
  logic [WIDTH-1:0] hi_out, lo_out;

  mdu_mips #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } res_t;

  // Architectural result of one operation given the HI/LO in place at completion.
  function automatic res_t model_result(input logic [2:0] o, input logic [31:0] a, b, hi, lo);
    res_t r;
    longint sa, sb, q, rm;
    logic [63:0] p;
    r.hi = hi;
    r.lo = lo;
    r.dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (o)
      3'd0: begin p = sa * sb; {r.hi, r.lo} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {r.hi, r.lo} = p; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          r.lo = '1; r.hi = a; r.dz = 1'b1;
        end else if (o == 3'd2 && a == 32'h8000_0000 && b == 32'hffff_ffff) begin
          r.lo = 32'h8000_0000; r.hi = 32'd0;
        end else if (o == 3'd2) begin
          q = sa / sb; rm = sa % sb;
          r.lo = q[31:0]; r.hi = rm[31:0];
        end else begin
          r.lo = a / b; r.hi = a % b;
        end
      end
      3'd4, 3'd5: begin
`ifdef MDU_MADD_EN
        p = (o == 3'd4) ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
        {r.hi, r.lo} = {hi, lo} + p;
`endif
      end
      default: ;
    endcase
    return r;
  endfunction

  // Cycle-level model: busy for WIDTH+1 edges after acceptance, result on the last.
  logic        m_busy, m_done, m_dz;
  logic [31:0] m_hi, m_lo, p_a, p_b;
  logic [2:0]  p_op;
  int          m_cnt;
  res_t        m_res;

  assign m_res = model_result(p_op, p_a, p_b, m_hi, m_lo);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_hi <= '0; m_lo <= '0; m_cnt <= 0;
      p_op <= '0; p_a <= '0; p_b <= '0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (!m_busy) begin
        if (start && op[2:1] != 2'b11) begin
          m_busy <= 1'b1; m_cnt <= WIDTH + 1;
          p_op <= op; p_a <= a_in; p_b <= b_in;
        end else begin
          if (hi_we) m_hi <= wdata;
          if (lo_we) m_lo <= wdata;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_dz <= m_res.dz;
          m_hi <= m_res.hi; m_lo <= m_res.lo;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en)
      check("cycle", 128'({busy, done, div_zero, hi_out, lo_out}),
            128'({m_busy, m_done, m_dz, m_hi, m_lo}));
  end

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hffff_ffff;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  // Caller must be at a negedge; returns edges from acceptance to done (bounded).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, b, input bit junk,
                        output int n);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); a_in = $urandom; b_in = $urandom;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (junk) begin
        start = (n == 5); hi_we = (n == 5); op = 3'b011; wdata = 32'd5;
      end
    end
    start = 1'b0; hi_we = 1'b0;
  endtask

  int n, pulses;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a_in = '0; b_in = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #1 cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_state", 128'({busy, done, div_zero, hi_out, lo_out}), 128'(0));

    run_op(3'd0, 32'hffff_fffd, 32'd7, 1'b0, n);
    check("mult_latency", 128'(n), 128'(33));
    check("mult_hi", 128'(hi_out), 128'(32'hffff_ffff));
    check("mult_lo", 128'(lo_out), 128'(32'hffff_ffeb));

    run_op(3'd3, 32'd100, 32'd7, 1'b0, n);
    check("divu_lo", 128'(lo_out), 128'(14));
    check("divu_hi", 128'(hi_out), 128'(2));
    run_op(3'd2, 32'hffff_fff9, 32'd2, 1'b0, n);  // back-to-back issue
    check("b2b_latency", 128'(n), 128'(33));
    check("div_lo", 128'(lo_out), 128'(32'hffff_fffd));
    check("div_hi", 128'(hi_out), 128'(32'hffff_ffff));

    run_op(3'd2, 32'h1234_5678, 32'd0, 1'b0, n);
    check("dz_flag", 128'({div_zero, done}), 128'(2'b11));
    check("dz_lo", 128'(lo_out), 128'(32'hffff_ffff));
    check("dz_hi", 128'(hi_out), 128'(32'h1234_5678));

    run_op(3'd2, 32'h8000_0000, 32'hffff_ffff, 1'b0, n);
    check("ovf", 128'({div_zero, hi_out, lo_out}), 128'({1'b0, 32'd0, 32'h8000_0000}));

    run_op(3'd1, 32'hffff_ffff, 32'hffff_ffff, 1'b1, n);
    check("multu_junk_lat", 128'(n), 128'(33));
    check("multu_hi", 128'(hi_out), 128'(32'hffff_fffe));
    check("multu_lo", 128'(lo_out), 128'(32'h0000_0001));
    lo_we = 1'b1; wdata = 32'd9;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo", 128'({hi_out, lo_out}), 128'({32'hffff_fffe, 32'd9}));

    // Asynchronous reset mid-operation
    start = 1'b1; op = 3'd0; a_in = 32'd6; b_in = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 128'({busy, done, hi_out, lo_out}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("rst_no_done", 128'(pulses), 128'(0));
    run_op(3'd0, 32'd6, 32'd7, 1'b0, n);
    check("mult_after_rst", 128'({hi_out, lo_out}), 128'({32'd0, 32'd42}));

    // Reserved op is ignored
    start = 1'b1; op = 3'b110;
    @(negedge clk);
    start = 1'b0;
    check("reserved_idle", 128'(busy), 128'(0));

    hi_we = 1'b1; wdata = 32'd0;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hffff_ffff;
    @(negedge clk);
    lo_we = 1'b0;
    run_op(3'd5, 32'd1, 32'd1, 1'b0, n);
    check("maddu_done", 128'(n), 128'(33));
`ifdef MDU_MADD_EN
    check("maddu", 128'({hi_out, lo_out}), 128'({32'd1, 32'd0}));
`else
    check("maddu_off", 128'({hi_out, lo_out}), 128'({32'd0, 32'hffff_ffff}));
`endif

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      a_in  = rnd_word();
      b_in  = rnd_word();
      hi_we = ($urandom_range(0, 7) == 0);
      lo_we = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
      if (i == 2000) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/mdu_mips.md
Name: mdu_mips

Overview:
- Parametrised iterative multiply/divide unit with HI/LO registers, for the next-generation MIPS core.
- Executes MULT/MULTU/DIV/DIVU at one bit per cycle and holds results in HI/LO for MFHI/MFLO.
- Sits beside the ALU. Issue logic starts it via start/busy and stalls on busy.
- HI/LO are writable directly for MTHI/MTLO.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. Minimum is 4.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset. Asynchronous, active-low. Clears all state.
- start  in  1  begin an operation. Sampled only while busy=0.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 11x reserved.
- a_in  in  WIDTH  Rs operand (multiplicand / dividend).
- b_in  in  WIDTH  Rt operand (multiplier / divisor).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO take the result.
- div_zero  out  1  one-cycle pulse with done when a DIV/DIVU had b_in=0.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE.
  - hi_out=0, lo_out=0, busy=0, done=0, div_zero=0.
  - Any in-flight result is discarded.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1 with a valid op latches a_in, b_in and op. For signed ops it records the operand signs and stores magnitudes. The counter loads WIDTH-1 and the state goes to RUN.
  - start=1 with a reserved op is ignored and the state stays IDLE.
  - hi_we/lo_we write wdata to HI/LO only if start is not also accepted that cycle. When start is accepted, the writes are dropped.
- RUN, one iteration per edge for WIDTH edges:
  - Multiply: shift-add on an unsigned 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract, producing a WIDTH-bit quotient and remainder.
  - After the iteration with counter=0, go to FIX.
- FIX, one edge, then back to IDLE:
  - Apply sign correction.
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
  - MULT/MULTU: HI takes product[2W-1:W], LO takes product[W-1:0].
  - DIV/DIVU: LO takes the quotient, HI takes the remainder.
  - done=1 for exactly this cycle.
- Timing:
  - busy=1 from the edge after start is accepted until the FIX edge. busy and done are never both 1.
  - Latency: start sampled at edge 0, HI/LO updated and done=1 after edge WIDTH+1.
  - A new start may be accepted on the cycle done is high, giving back-to-back issue.
- While busy:
  - start is ignored.
  - hi_we/lo_we are ignored; software must wait.
  - HI/LO hold their old values until FIX.
- Divide by zero (b_in=0): LO={WIDTH{1'b1}}, HI=a_in unchanged, div_zero pulses with done. Latency is unchanged.
- Signed overflow, DIV with most-negative / -1: LO=most-negative, HI=0. No flag.
- Inputs a_in, b_in and op are don't-care after the start cycle.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 100 (MADD) computes {HI,LO} = {HI,LO} + signed product.
  - op 101 (MADDU) computes {HI,LO} = {HI,LO} + unsigned product.
  - Both are 2*WIDTH-bit wrap-around additions performed in FIX. Latency equals MULT.
- Undefined:
  - ops 100/101 are accepted and run the full latency with done pulsing.
  - HI/LO are left unchanged.
  - No accumulator adder is synthesised.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> after 33 edges: done=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB. busy=1 for edges 1..32.
- DIVU a=100, b=7 -> LO=14, HI=2. DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x12345678, b=0 -> LO=0xFFFFFFFF, HI=0x12345678, div_zero and done high together for one cycle.
- Issue MULTU 0xFFFFFFFF*0xFFFFFFFF, then pulse start (op=DIVU) and hi_we (wdata=5) mid-run -> both ignored; HI=0xFFFFFFFE, LO=0x00000001. Then in IDLE lo_we with wdata=9 -> LO=9.
- Start MULT 6*7, deassert rst_n at edge 10 -> immediately busy=0, HI=LO=0, done never pulses. After release, MULT 6*7 -> LO=42, HI=0.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1*1 -> HI=1, LO=0. Without the macro, the same stimulus -> done pulses, HI/LO unchanged.
